// File: rtl/leaf_user_pkg.sv
// Shared constants and helpers for the leaf user-side merge kernel.
package leaf_user_pkg;
    localparam int PAYLOAD_BITS_DEFAULT = 32;
    localparam int MAX_IN = 8;
    localparam int IDX_W = 3;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_IN-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/leaf_user_sync_fifo.sv
// leaf_user_sync_fifo: single-clock FIFO whose head word is held in its own register.
// Latency: a word pushed at edge N is on head_dat_o after edge N; no bypass.
// Backpressure: full_o comes from the registered count; pushes while full and pops while empty are ignored.
module leaf_user_sync_fifo
    import leaf_user_pkg::*;
#(
    parameter int WIDTH = PAYLOAD_BITS_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_dat_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          head_dat_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [ptr_width(DEPTH):0] count_o
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = head_q;
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
        // The next head is either already stored or is the word being written right now.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_dat_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end
endmodule

// File: rtl/leaf_user_rr_merge.sv
// leaf_user_rr_merge: round-robin merge of NUM_IN vld/ack streams into one stream through a FIFO.
// Latency: a word accepted at edge N is presented on the output after edge N.
// Backpressure: all input acks drop while the registered FIFO count is full. Optional RR_MERGE_STATS_EN adds counters.
module leaf_user_rr_merge
    import leaf_user_pkg::*;
#(
    parameter int NUM_IN       = 5,
    parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                           clk_user,
    input  logic                           reset,
    input  logic [NUM_IN*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    input  logic [NUM_IN-1:0]              vld_interface2user,
    output logic [NUM_IN-1:0]              ack_user2interface,
    output logic [PAYLOAD_BITS-1:0]        din_leaf_user2interface,
    output logic                           vld_user2interface,
    input  logic                           ack_interface2user
`ifdef RR_MERGE_STATS_EN
    ,
    output logic [31:0]                    words_out_cnt,
    output logic [31:0]                    stall_cnt
`endif
);
    localparam int CW = ptr_width(FIFO_DEPTH) + 1;

    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [NUM_IN-1:0]       grant_oh;
    logic [NUM_IN-1:0]       scan_sel;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop;
    logic [PAYLOAD_BITS-1:0] push_dat;
    int                      scan_idx;

    // Scan from farthest to nearest so the nearest valid stream after last_grant wins.
    always_comb begin
        grant_oh = '0;
        scan_sel = '0;
        scan_idx = 0;
        if (!fifo_full) begin
            for (int off = NUM_IN; off >= 1; off--) begin
                scan_idx = int'(last_grant_q) + off;
                if (scan_idx >= NUM_IN) scan_idx = scan_idx - NUM_IN;
                scan_sel = NUM_IN'(1) << scan_idx;
                if ((vld_interface2user & scan_sel) != '0) grant_oh = scan_sel;
            end
        end
    end

    assign ack_user2interface = reset ? grant_oh : '0;
    assign push               = |ack_user2interface;

    always_comb begin
        push_dat = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (ack_user2interface[k]) push_dat = dout_leaf_interface2user[k*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (push) last_grant_d = onehot_to_idx(MAX_IN'(ack_user2interface));
    end

    always_ff @(posedge clk_user) begin
        if (!reset) begin
            last_grant_q <= IDX_W'(NUM_IN - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign vld_user2interface = (fifo_count != '0);
    assign pop                = ack_interface2user && !fifo_empty;

    leaf_user_sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_user),
        .rst_n      (reset),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (din_leaf_user2interface),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

`ifdef RR_MERGE_STATS_EN
    logic [31:0] words_out_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_user) begin
        if (!reset) begin
            words_out_cnt_q <= '0;
            stall_cnt_q     <= '0;
        end else begin
            if (pop) words_out_cnt_q <= words_out_cnt_q + 32'd1;
            if (vld_user2interface && !ack_interface2user) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign words_out_cnt = words_out_cnt_q;
    assign stall_cnt     = stall_cnt_q;
`endif
endmodule

// File: tb/tb_leaf_user_rr_merge.sv
// Directed bench for leaf_user_rr_merge: expected words go into a queue, a negedge monitor checks output transfers.
`timescale 1ns/1ps
module tb_leaf_user_rr_merge;
    localparam int NUM_IN = 5;
    localparam int PB     = 32;

    logic                 clk_user = 1'b0;
    logic                 reset;
    logic [NUM_IN*PB-1:0] dout;
    logic [NUM_IN-1:0]    vld_in;
    logic [NUM_IN-1:0]    ack_out;
    logic [PB-1:0]        din_out;
    logic                 vld_out;
    logic                 ack_in;
`ifdef RR_MERGE_STATS_EN
    logic [31:0]          words_out_cnt;
    logic [31:0]          stall_cnt;
`endif

    int            tests = 0;
    int            fails = 0;
    logic [PB-1:0] exp_q[$];

    always #5 clk_user = ~clk_user;

    leaf_user_rr_merge #(
        .NUM_IN       (NUM_IN),
        .PAYLOAD_BITS (PB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk_user                 (clk_user),
        .reset                    (reset),
        .dout_leaf_interface2user (dout),
        .vld_interface2user       (vld_in),
        .ack_user2interface       (ack_out),
        .din_leaf_user2interface  (din_out),
        .vld_user2interface       (vld_out),
        .ack_interface2user       (ack_in)
`ifdef RR_MERGE_STATS_EN
        ,
        .words_out_cnt            (words_out_cnt),
        .stall_cnt                (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_user);
        #1;
    endtask

    task automatic set_dat(input int k, input logic [31:0] v);
        dout[k*PB +: PB] = v;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ack_in = 1'b1;
        while ((vld_out !== 1'b0 || exp_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL drain: timeout with %0d words still expected", exp_q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
    endtask

    // Output scoreboard: every output transfer must match the oldest expected word.
    always @(negedge clk_user) begin
        if (reset === 1'b1 && vld_out === 1'b1 && ack_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got 0x%0h, expected no word", din_out);
            end else begin
                check("out_data", din_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   idx;
        int   n_ack;
        logic acked;
        int   eg;

        reset  = 1'b0;
        vld_in = '0;
        ack_in = 1'b0;
        dout   = '0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        @(negedge clk_user);
        check("rst_vld_out", 32'(vld_out), 32'd0);
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_din", din_out, 32'd0);

        // Latency: single word, visible only after its accept edge
        tick();
        set_dat(0, 32'hDEADBEEF);
        vld_in = 5'b00001;
        @(negedge clk_user);
        check("lat_ack", 32'(ack_out), 32'h01);
        check("lat_vld_before", 32'(vld_out), 32'd0);
        exp_q.push_back(32'hDEADBEEF);
        tick();
        vld_in = '0;
        check("lat_vld_after", 32'(vld_out), 32'd1);
        check("lat_din", din_out, 32'hDEADBEEF);
        drain();

        // Round-robin fairness with all inputs valid
        do_reset();
        for (int k = 0; k < NUM_IN; k++) set_dat(k, 32'h1000 + 32'(k));
        vld_in = '1;
        ack_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_user);
            check("rr_grant", 32'(ack_out), 32'(1 << (i % NUM_IN)));
            exp_q.push_back(32'h1000 + 32'(i % NUM_IN));
            tick();
        end
        vld_in = '0;
        drain();

        // Skip idle inputs: move last_grant to 1, then only 1 and 3 valid
        set_dat(1, 32'h2001);
        set_dat(3, 32'h2003);
        vld_in = 5'b00010;
        @(negedge clk_user);
        check("skip_setup", 32'(ack_out), 32'h02);
        exp_q.push_back(32'h2001);
        tick();
        vld_in = 5'b01010;
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 0) ? 3 : 1;
            @(negedge clk_user);
            check("skip_grant", 32'(ack_out), 32'(1 << eg));
            exp_q.push_back(32'h2000 + 32'(eg));
            tick();
        end
        vld_in = '0;
        drain();

        // Full back-pressure on stream 2
        ack_in = 1'b0;
        idx    = 0;
        n_ack  = 0;
        set_dat(2, 32'hA0);
        vld_in = 5'b00100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_user);
            acked = ack_out[2];
            if (acked) begin
                exp_q.push_back(32'hA0 + 32'(idx));
                n_ack++;
            end
            tick();
            if (acked) begin
                idx++;
                set_dat(2, 32'hA0 + 32'(idx));
            end
        end
        check("full_ack_count", 32'(n_ack), 32'd8);
        @(negedge clk_user);
        check("full_ack_low", 32'(ack_out), 32'd0);
        check("full_head", din_out, 32'hA0);
        tick();
        ack_in = 1'b1;
        @(negedge clk_user);
        check("full_no_push_T", 32'(ack_out), 32'd0);
        tick();
        @(negedge clk_user);
        check("full_push_T1", 32'(ack_out), 32'h04);
        for (int c = 0; c < 40 && idx < 16; c++) begin
            if (c > 0) @(negedge clk_user);
            acked = ack_out[2];
            if (acked) exp_q.push_back(32'hA0 + 32'(idx));
            tick();
            if (acked) begin
                idx++;
                set_dat(2, 32'hA0 + 32'(idx));
            end
        end
        vld_in = '0;
        check("full_all_sent", 32'(idx), 32'd16);
        drain();

        // Reset mid-stream: three buffered words are discarded
        ack_in = 1'b0;
        set_dat(2, 32'h30);
        vld_in = 5'b00100;
        tick();
        tick();
        tick();
        check("mid_vld_pre", 32'(vld_out), 32'd1);
        reset = 1'b0;
        set_dat(0, 32'h40);
        set_dat(1, 32'h41);
        set_dat(3, 32'h43);
        vld_in = 5'b01011;
        @(negedge clk_user);
        check("mid_rst_ack", 32'(ack_out), 32'd0);
        tick();
        reset  = 1'b1;
        vld_in = '0;
        exp_q.delete();
        @(negedge clk_user);
        check("mid_vld_post", 32'(vld_out), 32'd0);
        check("mid_ack_post", 32'(ack_out), 32'd0);
        check("mid_din_post", din_out, 32'd0);
        tick();
        vld_in = 5'b01011;
        @(negedge clk_user);
        check("mid_first_grant", 32'(ack_out), 32'h01);
        exp_q.push_back(32'h40);
        tick();
        vld_in = '0;
        check("mid_out_vld", 32'(vld_out), 32'd1);
        ack_in = 1'b1;
        tick();
        check("mid_count1_empty", 32'(vld_out), 32'd0);
        drain();

`ifdef RR_MERGE_STATS_EN
        // Stats: 10 words out, 4 stall cycles
        do_reset();
        @(negedge clk_user);
        check("stats_rst_words", words_out_cnt, 32'd0);
        check("stats_rst_stall", stall_cnt, 32'd0);
        tick();
        ack_in = 1'b0;
        set_dat(0, 32'h500);
        vld_in = 5'b00001;
        @(negedge clk_user);
        check("stats_ack", 32'(ack_out), 32'h01);
        exp_q.push_back(32'h500);
        tick();
        vld_in = '0;
        repeat (4) @(posedge clk_user);
        #1;
        ack_in = 1'b1;
        for (int w = 1; w < 10; w++) begin
            set_dat(0, 32'h500 + 32'(w));
            vld_in = 5'b00001;
            @(negedge clk_user);
            check("stats_ack", 32'(ack_out), 32'h01);
            exp_q.push_back(32'h500 + 32'(w));
            tick();
        end
        vld_in = '0;
        drain();
        tick();
        check("stats_words", words_out_cnt, 32'd10);
        check("stats_stall", stall_cnt, 32'd4);
        do_reset();
        @(negedge clk_user);
        check("stats_clr_words", words_out_cnt, 32'd0);
        check("stats_clr_stall", stall_cnt, 32'd0);
        tick();
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/leaf_user_rr_merge.md
Name: leaf_user_rr_merge

Overview:
- User-side kernel stage that sits directly downstream of the leaf interface's input ports and upstream of its single output port.
- Consumes up to NUM_IN independent 32-bit vld/ack streams (interface2user), merges them by round-robin arbitration into a small FIFO, and emits one vld/ack stream (user2interface).
- Standard fan-in kernel for i5o1-style leaves. Runs entirely in the user clock domain.

Parameters:
- NUM_IN, 5, number of input streams (1..8)
- PAYLOAD_BITS, 32, data width per word
- FIFO_DEPTH, 8, merge FIFO entries (power of two, >=2)

Ports:
- clk_user  input  1  user clock; the only clock
- reset  input  1  synchronous, active-low reset
- dout_leaf_interface2user  input  NUM_IN*PAYLOAD_BITS  input payloads; slice k is stream k
- vld_interface2user  input  NUM_IN  per-stream valid
- ack_user2interface  output  NUM_IN  per-stream accept (one-hot or zero)
- din_leaf_user2interface  output  PAYLOAD_BITS  merged output payload
- vld_user2interface  output  1  output valid
- ack_interface2user  input  1  output accept from interface

Behaviour:
- Handshake on every port: a word transfers in a cycle where vld and ack are both 1. vld/data are held until accepted. ack may be combinational on vld.
- Reset (reset==0 at a clk_user edge): FIFO empty, count=0, last_grant=NUM_IN-1, vld_user2interface=0, ack_user2interface=0, din_leaf_user2interface=0. Any in-flight word is discarded.
- Arbiter:
  - Combinational, using registered state only.
  - If count==FIFO_DEPTH, no grant; all ack=0.
  - Otherwise grant = first k with vld[k]=1, scanning cyclically from last_grant+1 (wraps NUM_IN-1 -> 0).
  - ack_user2interface = onehot(grant). No vld gives ack=0.
  - last_grant updates to the granted index only on a transfer.
- FIFO:
  - Push the granted payload on an input transfer.
  - Pop on an output transfer.
  - Output is the head entry, with vld_user2interface = (count!=0).
  - Latency: a word accepted at edge N is visible at the output after edge N, i.e. the earliest output transfer is cycle N+1.
  - No bypass.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Full: the full decision uses the registered count. A pop in the same cycle does not enable a push. The push resumes the next cycle.
- Empty: vld_user2interface=0. din holds the last head value and is don't-care.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Ordering: per-stream order is preserved. Inter-stream order follows grant order.
- Fairness: with all inputs continuously valid and the output always acked, grants cycle 0,1,...,NUM_IN-1,0,...

Optional Feature:
- Macro RR_MERGE_STATS_EN.
- When defined:
  - Adds output words_out_cnt (32 bits): counts output transfers.
  - Adds output stall_cnt (32 bits): counts cycles with vld_user2interface=1 and ack_interface2user=0.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined: these ports and their logic are absent. Data-path behaviour is identical either way.

Decomposition:
- Package leaf_user_pkg holds:
  - PAYLOAD_BITS_DEFAULT=32
  - a clog2-based function for pointer widths
  - the onehot-to-index helper function
- Sub-module leaf_user_sync_fifo: single-clock, registered-head FIFO with push/pop/full/empty/count.
- The arbiter and the counters stay in the top module.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill the FIFO with 3 words, assert reset=0 for 1 cycle.
  - Required: vld_user2interface=0 and ack_user2interface=0 next cycle. The first post-reset word arrives with count 1 and is granted to input 0 if several inputs are valid.
- Round-robin fairness:
  - Stimulus: all 5 inputs valid with payload 0x1000+k, output ack=1.
  - Required: output sequence is 0x1000, 0x1001, 0x1002, 0x1003, 0x1004, 0x1000, with one grant per cycle.
- Skip idle inputs:
  - Stimulus: only inputs 1 and 3 valid, last_grant=1.
  - Required: grants go 3, 1, 3, 1.
- Full back-pressure:
  - Stimulus: ack_interface2user=0, input 2 streams 0xA0..0xAF.
  - Required: exactly 8 acks (0xA0..0xA7), then ack=0.
  - Release output ack in cycle T: no push in T, push of 0xA8 in T+1, output order 0xA0..0xAF intact.
- Latency:
  - Stimulus: empty FIFO, single word 0xDEADBEEF accepted at edge N.
  - Required: vld_user2interface=1 with that data in the cycle after N, not before.
- Stats (RR_MERGE_STATS_EN defined):
  - Stimulus: 10 words transferred, with 4 stall cycles injected.
  - Required: words_out_cnt=10, stall_cnt=4. After reset, both counters read 0.
